// File: rtl/prefetch_buffer.sv
// Instruction prefetch stage: sequential word fetches over a req/gnt/rvalid
// memory port, queued with their PCs in a small FIFO for the decode stage.
module prefetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        res_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t          state, state_nxt;
  logic [31:0]     fetch_pc;
  logic [31:0]     req_pc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     fifo_data [DEPTH];
  logic [31:0]     fifo_pc   [DEPTH];

  logic            in_wait;
  logic            pop;
  logic            push;
  logic            issue;
  logic            accept;
  logic [CW:0]     occ;

  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? fifo_data[rd_ptr] : NOP;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : 32'h0;

  assign in_wait = (state == WAIT);
  assign pop     = instr_valid & instr_ready;
  // Occupancy the FIFO will see once the in-flight word lands, net of this cycle's pop.
  assign occ     = {1'b0, count} + (CW+1)'(in_wait) - (CW+1)'(pop);
  assign issue   = res_n & ~redirect & ((state == IDLE) | (in_wait & imem_rvalid))
                 & (occ < (CW+1)'(DEPTH));
  assign push    = in_wait & imem_rvalid & ~redirect;
  assign accept  = issue & imem_gnt;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT: begin
        if (redirect)         state_nxt = imem_rvalid ? IDLE : DISCARD;
        else if (imem_rvalid) state_nxt = accept ? WAIT : IDLE;
      end
      DISCARD: if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= IDLE;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      req_pc   <= 32'h0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) req_pc <= fetch_pc;
      if (redirect) begin
        // Flush: any queued words and any pending response belong to the old stream.
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push)   wr_ptr   <= wr_ptr + PW'(1);
        if (pop)    rd_ptr   <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: directed vector table, reset/wrap sequences and a
// randomized run against a stream-level reference model with a memory responder.
module tb_prefetch_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        res_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  prefetch_buffer #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .res_n(res_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic logic [31:0] tag(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  task automatic chk_out(input string nm, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] pc, input logic [31:0] data);
    chk({nm, ".req"},  32'(imem_req),    32'(req));
    chk({nm, ".addr"}, imem_addr,        addr);
    chk({nm, ".vld"},  32'(instr_valid), 32'(vld));
    chk({nm, ".pc"},   instr_pc,         pc);
    chk({nm, ".data"}, instr_data,       data);
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] rpc);
    @(negedge clk);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    instr_ready = rdy; redirect = rdr; redirect_pc = rpc;
    #1;
  endtask

  typedef struct {
    logic gnt; logic rv; logic [31:0] rd; logic rdy; logic rdr; logic [31:0] rpc;
    logic req; logic [31:0] addr; logic vld; logic [31:0] pc; logic [31:0] data;
  } vec_t;
  vec_t vecs[15];

  // Memory responder and stream-level reference state.
  bit          pend;
  int          dly;
  logic [31:0] paddr;
  logic [31:0] exp_pc;
  bit          prev_req, prev_gnt, prev_rdr;
  logic [31:0] prev_addr;
  int          idle_cyc;
  logic [31:0] got[$];

  task automatic step(input bit rnd, input bit frdr, input logic [31:0] rpc, input bit frdy);
    bit rv;
    @(negedge clk);
    rv = pend && (dly == 0);
    if (pend && dly > 0) dly--;
    imem_rvalid = rv;
    imem_rdata  = rv ? tag(paddr) : $urandom;
    if (rnd) begin
      imem_gnt    = ($urandom_range(0, 9) < 7);
      instr_ready = ($urandom_range(0, 9) < 6);
      redirect    = ($urandom_range(0, 39) == 0);
      redirect_pc = $urandom;
    end else begin
      imem_gnt = 1'b1; instr_ready = frdy; redirect = frdr; redirect_pc = rpc;
    end
    #1;
    if (prev_rdr) chk("flush_empty", 32'(instr_valid), 32'd0);
    if (!instr_valid) begin
      chk("idle_data", instr_data, NOP);
      chk("idle_pc", instr_pc, 32'h0);
    end
    if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
    if (redirect) chk("redirect_noreq", 32'(imem_req), 32'd0);
    if (prev_req && !prev_gnt && !redirect) begin
      chk("hold_req", 32'(imem_req), 32'd1);
      chk("hold_addr", imem_addr, prev_addr);
    end
    chk("one_outstanding", 32'(imem_req && pend && !rv), 32'd0);
    if (instr_valid && instr_ready) begin
      chk("stream_pc", instr_pc, exp_pc);
      chk("stream_data", instr_data, tag(exp_pc));
      got.push_back(instr_pc);
      exp_pc   = exp_pc + 32'd4;
      idle_cyc = 0;
    end else begin
      idle_cyc++;
    end
    chk("progress_bound", 32'(idle_cyc > 80), 32'd0);
    if (idle_cyc > 80) idle_cyc = 0;
    if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
    if (rv) pend = 1'b0;
    if (imem_req && imem_gnt) begin
      pend  = 1'b1;
      paddr = imem_addr;
      dly   = $urandom_range(0, 2);
    end
    prev_req = imem_req; prev_gnt = imem_gnt; prev_rdr = redirect; prev_addr = imem_addr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           gnt rv rd            rdy rdr rpc         req addr       vld pc         data
    vecs[0]  = '{1, 0, 32'h0,        1, 0, 32'h0,       1, 32'h0,     0, 32'h0,     NOP};
    vecs[1]  = '{1, 1, tag(32'h0),   1, 0, 32'h0,       1, 32'h4,     0, 32'h0,     NOP};
    vecs[2]  = '{1, 1, tag(32'h4),   1, 0, 32'h0,       1, 32'h8,     1, 32'h0,     tag(32'h0)};
    vecs[3]  = '{1, 1, tag(32'h8),   1, 0, 32'h0,       1, 32'hC,     1, 32'h4,     tag(32'h4)};
    vecs[4]  = '{1, 1, tag(32'hC),   0, 0, 32'h0,       0, 32'h10,    1, 32'h8,     tag(32'h8)};
    vecs[5]  = '{1, 0, 32'h0,        0, 0, 32'h0,       0, 32'h10,    1, 32'h8,     tag(32'h8)};
    vecs[6]  = '{0, 0, 32'h0,        1, 0, 32'h0,       1, 32'h10,    1, 32'h8,     tag(32'h8)};
    vecs[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,       1, 32'h10,    1, 32'hC,     tag(32'hC)};
    vecs[8]  = '{1, 0, 32'h0,        0, 0, 32'h0,       1, 32'h10,    1, 32'hC,     tag(32'hC)};
    vecs[9]  = '{1, 0, 32'h0,        1, 1, 32'h103,     0, 32'h14,    1, 32'hC,     tag(32'hC)};
    vecs[10] = '{1, 0, 32'h0,        1, 0, 32'h0,       0, 32'h100,   0, 32'h0,     NOP};
    vecs[11] = '{1, 1, tag(32'h10),  1, 0, 32'h0,       0, 32'h100,   0, 32'h0,     NOP};
    vecs[12] = '{1, 0, 32'h0,        1, 0, 32'h0,       1, 32'h100,   0, 32'h0,     NOP};
    vecs[13] = '{0, 1, tag(32'h100), 1, 0, 32'h0,       1, 32'h104,   0, 32'h0,     NOP};
    vecs[14] = '{0, 0, 32'h0,        0, 0, 32'h0,       1, 32'h104,   1, 32'h100,   tag(32'h100)};

    res_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    #1 chk_out("reset", 0, 32'h0, 0, 32'h0, NOP);
    @(negedge clk) res_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].gnt, vecs[i].rv, vecs[i].rd, vecs[i].rdy, vecs[i].rdr, vecs[i].rpc);
      chk_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].vld,
              vecs[i].pc, vecs[i].data);
    end

    // Queue one entry and leave a request in flight, then reset asynchronously.
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    chk_out("inflight", 1, 32'h104, 1, 32'h100, tag(32'h100));
    @(negedge clk);
    #2 res_n = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0;
    #1 chk_out("async_reset", 0, 32'h0, 0, 32'h0, NOP);
    @(negedge clk) res_n = 1'b1;
    drive(1, 1, 32'hBAD0_BAD0, 1, 0, 32'h0);
    chk_out("rst_r0", 1, 32'h0, 0, 32'h0, NOP);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk_out("rst_r1", 0, 32'h4, 0, 32'h0, NOP);
    drive(1, 1, tag(32'h0), 1, 0, 32'h0);
    chk_out("rst_r2", 1, 32'h4, 0, 32'h0, NOP);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk_out("rst_r3", 0, 32'h8, 1, 32'h0, tag(32'h0));

    // Clean restart for the randomized run.
    @(negedge clk);
    res_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    @(negedge clk) res_n = 1'b1;
    pend = 1'b0; dly = 0; paddr = 32'h0; exp_pc = 32'h0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_rdr = 1'b0; prev_addr = 32'h0; idle_cyc = 0;
    repeat (3000) step(1, 0, 32'h0, 0);

    // Redirect onto the top word: the stream must wrap through zero.
    step(0, 1, 32'hFFFF_FFFC, 1);
    got.delete();
    for (int k = 0; k < 30 && got.size() < 3; k++) step(0, 0, 32'h0, 1);
    chk("wrap_count", got.size(), 32'd3);
    if (got.size() >= 3) begin
      chk("wrap_pc0", got[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", got[1], 32'h0);
      chk("wrap_pc2", got[2], 32'h4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prefetch_buffer.md
# prefetch_buffer

Instruction prefetch stage between the instruction memory and the decode stage. Issues sequential word fetches over a req/gnt/rvalid memory handshake and queues returned instructions with their PCs in a small FIFO. Presents them to decode over a valid/ready handshake. Flushes and restarts on a control-flow redirect from the branch/jump logic.

## Interface
- RESET_PC, 32'h0, first fetch address after reset.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- res_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch word address; bits [1:0] always 0.
- imem_gnt  in  1  request accepted this cycle when imem_req & imem_gnt.
- imem_rvalid  in  1  read data valid for the single outstanding request.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  FIFO head valid.
- instr_data  out  32  head instruction; 32'h0000_0013 (NOP) when !instr_valid.
- instr_pc  out  32  head PC; 0 when !instr_valid.
- instr_ready  in  1  decode consumes head when instr_valid & instr_ready (pop).
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  restart address; bits [1:0] ignored (treated as 0).

## Operation
- State: fetch_pc, FIFO (data+pc per entry), count (clog2(DEPTH)+1 bits), FSM {IDLE, WAIT, DISCARD}.
  - IDLE: no request in flight.
  - WAIT: one accepted request; its response will be kept.
  - DISCARD: one accepted request whose response will be dropped.
- At most one outstanding request. Issue condition, excluding redirect cycles:
  - state==IDLE, or state==WAIT with imem_rvalid this cycle;
  - and count + (state==WAIT) − pop < DEPTH.
- imem_req is combinational from that condition. imem_addr = fetch_pc.
- Accept (req & gnt): state→WAIT, fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC → 0).
- Without gnt, imem_req and imem_addr hold stable until gnt. The only exception is redirect.
- WAIT & rvalid: push {imem_rdata, pc of that request}. State→IDLE unless a new accept occurs in the same cycle (then WAIT).
- DISCARD & rvalid: drop data, no push. State→IDLE.
- rvalid in IDLE is ignored (stray response, e.g. after reset).
- Simultaneous push and pop: count unchanged. Push never targets a full FIFO, guaranteed by the issue condition.
- Redirect cycle:
  - imem_req=0.
  - A pop in the same cycle completes normally.
  - All FIFO entries are flushed: count←0 next cycle.
  - fetch_pc←{redirect_pc[31:2],2'b00}.
  - WAIT without rvalid → DISCARD; WAIT with rvalid → IDLE with the data dropped; DISCARD stays DISCARD unless rvalid.
- After redirect, the first request issues the next cycle if IDLE; otherwise after the discarded response returns.
- Redirect has priority over push; the push in that cycle is dropped.

## Timing
- Reset (async, any time, including mid-request):
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_data=NOP, instr_pc=0.
  - count=0, FSM=IDLE; in-flight responses are lost.
- First cycle after res_n rises: imem_req=1, imem_addr=RESET_PC.
- Latency with gnt=1 and rvalid the cycle after accept: request at cycle N, rvalid at N+1, instr_valid at N+2.
- Throughput: back-to-back accept on each rvalid cycle gives 1 instruction/cycle with instr_ready=1.
- Backpressure: with instr_ready=0, fetching stops once count + in-flight = DEPTH. Fetch resumes in the cycle of the pop, since pop is counted in the issue condition.
- Redirect at cycle R: FIFO empty and instr_valid=0 at R+1. Redirected request at R+1 if IDLE. First redirected instr_valid no earlier than R+3.
- All outputs except imem_req/imem_addr derive from registers; imem_req/imem_addr are combinational from state, count, instr_ready, imem_rvalid, redirect.

## Test plan
- Reset release, gnt=1, rvalid 1 cycle later, ready=1, imem_rdata=addr-tagged → instr_pc 0,4,8,… one per cycle from cycle 2, instr_data matching; no gaps.
- ready=0 for 10 cycles, DEPTH=2 → exactly 2 accepts, imem_req low afterwards. Ready high → PCs 0,4 then 8 with no loss/duplication.
- gnt held low 3 cycles with addr 0x10 → imem_req=1 and imem_addr=0x10 stable throughout; accept on 4th cycle; fetch_pc→0x14.
- Redirect to 0x103 while a request to 0x20 is outstanding, rvalid 3 cycles later → 0x20 data dropped, FIFO empty at R+1; next request addr 0x100 issued only after the dropped rvalid; first delivered instr_pc=0x100.
- redirect_pc=0xFFFF_FFFC → delivered PCs 0xFFFF_FFFC, 0x0, 0x4.
- res_n pulsed low with FIFO full and a request in flight, stray rvalid after release → all outputs at reset values; stray rvalid ignored; fetch restarts at RESET_PC.
